// File: rtl/modular_addsub_pipe_pkg.sv
// Shared operation codes, width limits and the operation enum for the modular add/sub pipeline.
`ifndef MODULAR_ADDSUB_PIPE_DEFS
`define MODULAR_ADDSUB_PIPE_DEFS
`define OP_ADD 1'b0
`define OP_SUB 1'b1
`define MODULAR_ADDSUB_WIDTH_OK(w) (((w) >= modular_addsub_pipe_pkg::WIDTH_MIN) && ((w) <= modular_addsub_pipe_pkg::WIDTH_MAX))
`endif

package modular_addsub_pipe_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic {
    OP_ADD_E = `OP_ADD,
    OP_SUB_E = `OP_SUB
  } op_e;

endpackage

// File: rtl/modular_addsub_pipe_cla_adder_n.sv
// WIDTH-bit carry-lookahead adder built from per-bit half-sum, generate and propagate terms.
module cla_adder_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] bb,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] w_h;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_c;

  assign w_h = a ^ bb;
  assign w_g = a & bb;
  assign w_p = a | bb;

  always_comb begin
    w_c    = '0;
    w_c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
  end

  assign sum  = w_h ^ w_c[WIDTH-1:0];
  assign cout = w_c[WIDTH];

endmodule

// File: rtl/modular_addsub_pipe.sv
// Two-stage modular adder/subtractor: lookahead sum in stage 1, modulus correction into the
// output register in stage 2, with valid/ready flow control sustaining one beat per cycle.
module modular_addsub_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             err
);

  import modular_addsub_pipe_pkg::*;

  if (!`MODULAR_ADDSUB_WIDTH_OK(WIDTH)) begin : g_bad_width
    $error("modular_addsub_pipe: WIDTH out of range");
  end

  logic             w_s1_en;
  logic             w_s2_en;
  logic [WIDTH-1:0] w_bb;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_err1;

  logic             r_s1_valid;
  logic [WIDTH:0]   r_s1_s;
  op_e              r_s1_op;
  logic [WIDTH-1:0] r_s1_m;
  logic             r_s1_err;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_r;
  logic             r_s2_err;

  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH-1:0] w_r_add;
  logic [WIDTH-1:0] w_r_sub;
  logic [WIDTH-1:0] w_r2;

  assign w_s2_en  = !r_s2_valid || out_ready;
  assign w_s1_en  = !r_s1_valid || w_s2_en;
  assign in_ready = w_s1_en;

  // Subtraction is a + ~b + 1, so the operation bit doubles as the carry-in.
  assign w_bb   = (op == `OP_SUB) ? ~b : b;
  assign w_err1 = (m == '0) || (a >= m) || (b >= m);

  cla_adder_n #(
    .WIDTH (WIDTH)
  ) u_cla (
    .a    (a),
    .bb   (w_bb),
    .cin  (op),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Add compares on WIDTH+1 bits so a carry-out still triggers the subtract of m;
  // sub reads a clear carry-out as a borrow and wraps back by adding m.
  assign w_m_ext = {1'b0, r_s1_m};
  assign w_r_add = (r_s1_s >= w_m_ext) ? (r_s1_s[WIDTH-1:0] - r_s1_m) : r_s1_s[WIDTH-1:0];
  assign w_r_sub = r_s1_s[WIDTH] ? r_s1_s[WIDTH-1:0] : (r_s1_s[WIDTH-1:0] + r_s1_m);
  assign w_r2    = r_s1_err ? '0 : ((r_s1_op == OP_SUB_E) ? w_r_sub : w_r_add);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_s     <= '0;
      r_s1_op    <= OP_ADD_E;
      r_s1_m     <= '0;
      r_s1_err   <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_r     <= '0;
      r_s2_err   <= 1'b0;
    end else begin
      if (w_s1_en) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_s   <= {w_cout, w_sum};
          r_s1_op  <= op_e'(op);
          r_s1_m   <= m;
          r_s1_err <= w_err1;
        end
      end
      if (w_s2_en) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_r   <= w_r2;
          r_s2_err <= r_s1_err;
        end
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign r         = r_s2_r;
  assign err       = r_s2_err;

endmodule

// File: tb/tb_modular_addsub_pipe.sv
// Directed and randomized bench for modular_addsub_pipe with a queue-based arithmetic reference.
module tb_modular_addsub_pipe;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] m;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] r;
  logic         err;

  int           n_vec = 0;
  int           n_err = 0;
  logic [W:0]   exp_q[$];
  bit           last_acc;
  bit           stall_prev;
  logic [W-1:0] stall_r;
  logic         stall_e;
  int           idx;

  modular_addsub_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .m         (m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference: {err, r} straight from modular arithmetic on integers.
  function automatic logic [W:0] model(input logic o, input int ai, input int bi, input int mi);
    if (mi == 0 || ai >= mi || bi >= mi) return {1'b1, {W{1'b0}}};
    if (o == 1'b0) return {1'b0, W'((ai + bi) % mi)};
    return {1'b0, W'((ai - bi + mi) % mi)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0 ] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic o, input int ai, input int bi, input int mi);
    in_valid = v;
    op       = o;
    a        = W'(ai);
    b        = W'(bi);
    m        = W'(mi);
  endtask

  // Called at a falling edge with inputs driven; scores the cycle, then advances one clock.
  task automatic cycle();
    logic [W:0] e;
    #1;
    if (stall_prev) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_r", 32'(r), 32'(stall_r));
      check("stall_err", 32'(err), 32'(stall_e));
    end
    last_acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("r", 32'(r), 32'(e[W-1:0]));
        check("err", 32'(err), 32'(e[W]));
      end
    end
    if (last_acc) exp_q.push_back(model(op, int'(a), int'(b), int'(m)));
    stall_prev = out_valid && !out_ready;
    stall_r    = r;
    stall_e    = err;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_one(input logic o, input int ai, input int bi, input int mi,
                          input int exp_r, input int exp_e);
    out_ready = 1'b1;
    drive(1'b1, o, ai, bi, mi);
    cycle();
    check("accept", 32'(last_acc), 32'd1);
    in_valid = 1'b0;
    check("lat_early", 32'(out_valid), 32'd0);
    cycle();
    check("lat_valid", 32'(out_valid), 32'd1);
    check("const_r", 32'(r), 32'(exp_r));
    check("const_err", 32'(err), 32'(exp_e));
    cycle();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) cycle();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    out_ready  = 1'b1;
    stall_prev = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_r", 32'(r), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic add/sub, carry-out, equal-operand subtract, unit modulus
    send_one(1'b0, 9, 7, 13, 3, 0);
    send_one(1'b1, 3, 7, 13, 9, 0);
    send_one(1'b0, 14, 14, 15, 13, 0);
    send_one(1'b1, 5, 5, 15, 0, 0);
    send_one(1'b0, 0, 0, 1, 0, 0);
    send_one(1'b1, 0, 0, 13, 0, 0);

    // Back-to-back stream, no bubbles
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, i, 10 - i, 11);
      #1;
      check("stream_in_ready", 32'(in_ready), 32'd1);
      if (i >= 2) begin
        check("stream_valid", 32'(out_valid), 32'd1);
        check("stream_r", 32'(r), 32'd10);
      end
      cycle();
    end
    in_valid = 1'b0;
    check("stream_tail_valid", 32'(out_valid), 32'd1);
    drain();

    // Backpressure: stall 4 cycles, then toggle out_ready
    out_ready = 1'b0;
    idx = 1;
    for (int c = 0; c < 40 && (idx <= 6 || exp_q.size() > 0); c++) begin
      if (c >= 4) out_ready = (c % 2 == 0);
      drive(idx <= 6, 1'b1, idx, 2, 13);
      #1;
      if (c == 2 || c == 3) check("bp_in_ready", 32'(in_ready), 32'd0);
      cycle();
      if (last_acc) idx++;
    end
    check("bp_done", 32'(exp_q.size() == 0 && idx == 7), 32'd1);
    in_valid = 1'b0;

    // Error beats followed by a clean one
    send_one(1'b0, 13, 1, 13, 0, 1);
    send_one(1'b0, 0, 0, 0, 0, 1);
    send_one(1'b0, 12, 2, 13, 1, 0);

    // Reset with both stages full
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1, 2, 13);
    cycle();
    drive(1'b1, 1'b0, 3, 4, 13);
    cycle();
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    stall_prev = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_r", 32'(r), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("no_stale", 32'(out_valid), 32'd0);
      cycle();
    end
    send_one(1'b0, 6, 6, 7, 5, 0);

    // Randomized traffic against the reference queue
    for (int c = 0; c < 400; c++) begin
      int mi, ai, bi;
      mi = $urandom_range(1, 15);
      ai = $urandom_range(0, mi - 1);
      bi = $urandom_range(0, mi - 1);
      if ($urandom_range(0, 9) == 0) begin
        mi = $urandom_range(0, 15);
        ai = $urandom_range(0, 15);
        bi = $urandom_range(0, 15);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ai, bi, mi);
      cycle();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
